arm_prefetch_unit: RTL and testbench

- Parametrised successor to the core's inline fetch-stage PC logic.
- Owns the program counter and issues ARM (word) or Thumb (halfword) opcode fetches on the memory interface, honouring nWAIT.
- Buffers fetched instructions in a QUEUE_DEPTH-entry prefetch FIFO and presents them to decode through a valid/ready handshake.
- Branch/BX redirects flush the queue and the in-flight access, then restart fetch at the target in the requested instruction set.

---
 rtl/arm_prefetch_unit_if.sv | 52 +++++
 rtl/arm_prefetch_unit.sv | 179 +++++++++++++++++
 tb/tb_arm_prefetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/arm_prefetch_unit_if.sv
// Fetch-side bus of arm_prefetch_unit: memory request/response, redirect
// request from execute and the decode-facing instruction handshake.
// Optional macro FETCH_ABORT_EN adds abort / inst_abort.
interface arm_prefetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    // memory side
    logic              nWAIT;
    logic [31:0]       D;
    logic [ADDR_W-1:0] A;
    logic              nMREQ;
    logic              seq;
    logic [1:0]        mas;
    logic              nOPC;
    // redirect from execute
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              redirect_thumb;
    // decode side
    logic              dec_ready;
    logic              inst_valid;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_thumb;
    logic              tbit;
`ifdef FETCH_ABORT_EN
    logic              abort;
    logic              inst_abort;
`endif

    // prefetch unit side
    modport master (
        input  nWAIT, D, redirect_valid, redirect_target, redirect_thumb, dec_ready,
`ifdef FETCH_ABORT_EN
        input  abort,
        output inst_abort,
`endif
        output A, nMREQ, seq, mas, nOPC,
        output inst_valid, inst_data, inst_pc, inst_thumb, tbit
    );

    // memory / execute / decode side
    modport slave (
        output nWAIT, D, redirect_valid, redirect_target, redirect_thumb, dec_ready,
`ifdef FETCH_ABORT_EN
        output abort,
        input  inst_abort,
`endif
        input  A, nMREQ, seq, mas, nOPC,
        input  inst_valid, inst_data, inst_pc, inst_thumb, tbit
    );
endinterface

// File: rtl/arm_prefetch_unit.sv
// ARM/Thumb prefetch unit: owns the PC, issues opcode fetches honouring
// nWAIT, buffers them in a QUEUE_DEPTH-entry FIFO for decode, and flushes
// on branch/BX redirects.
// Optional macro FETCH_ABORT_EN: faulted fetches are flagged and stop fetch
// until the next redirect.
module arm_prefetch_unit #(
    parameter int unsigned      ADDR_W       = 32,
    parameter int unsigned      QUEUE_DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input logic                 mclk,
    input logic                 nReset,
    arm_prefetch_unit_if.master bus
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FULL
`ifdef FETCH_ABORT_EN
        ,
        S_ABORTED
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              tbit_q, tbit_d;
    logic              seq_q, seq_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

    logic [31:0]       fifo_data_q  [QUEUE_DEPTH];
    logic [31:0]       fifo_data_d  [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [QUEUE_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d    [QUEUE_DEPTH];
    logic              fifo_thumb_q [QUEUE_DEPTH];
    logic              fifo_thumb_d [QUEUE_DEPTH];
`ifdef FETCH_ABORT_EN
    logic              fifo_abort_q [QUEUE_DEPTH];
    logic              fifo_abort_d [QUEUE_DEPTH];
`endif

    logic              req;
    logic              complete;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [15:0]       half_sel;
    logic [31:0]       push_data;
    logic [ADDR_W-1:0] align_mask;

    // Request, completion and FIFO handshake decode
    always_comb begin
        head_valid = (count_q != '0);
        req        = (state_q == S_FETCH) && (count_q < CNT_W'(QUEUE_DEPTH));
        complete   = req && bus.nWAIT;
        // a redirect discards both the completing access and any pop
        push       = complete && !bus.redirect_valid;
        pop        = head_valid && bus.dec_ready && !bus.redirect_valid;
        half_sel   = pc_q[1] ? bus.D[31:16] : bus.D[15:0];
        push_data  = tbit_q ? {16'h0000, half_sel} : bus.D;
        align_mask = bus.redirect_thumb ? ADDR_W'(1) : ADDR_W'(3);
    end

    // Next-state: FSM, PC/tbit/seq tracking and FIFO bookkeeping
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tbit_d       = tbit_q;
        seq_d        = seq_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_data_d  = fifo_data_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_thumb_d = fifo_thumb_q;
`ifdef FETCH_ABORT_EN
        fifo_abort_d = fifo_abort_q;
`endif

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (push && !pop && count_q == CNT_W'(QUEUE_DEPTH - 1)) state_d = S_FULL;
            S_FULL:  if (pop) state_d = S_FETCH;
            default: state_d = state_q;
        endcase
`ifdef FETCH_ABORT_EN
        if (push && bus.abort) state_d = S_ABORTED;
`endif

        // seq holds through wait states, otherwise tracks last-cycle completion
        if (req && !bus.nWAIT) seq_d = seq_q;
        else                   seq_d = complete;

        if (complete) pc_d = pc_q + (tbit_q ? ADDR_W'(2) : ADDR_W'(4));

        if (push) begin
            fifo_data_d[wr_ptr_q]  = push_data;
            fifo_pc_d[wr_ptr_q]    = pc_q;
            fifo_thumb_d[wr_ptr_q] = tbit_q;
`ifdef FETCH_ABORT_EN
            fifo_abort_d[wr_ptr_q] = bus.abort;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.redirect_valid) begin
            state_d  = S_FETCH;
            pc_d     = bus.redirect_target & ~align_mask;
            tbit_d   = bus.redirect_thumb;
            seq_d    = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // State and FIFO registers
    always_ff @(posedge mclk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VECTOR;
            tbit_q   <= 1'b0;
            seq_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_thumb_q[i] <= 1'b0;
`ifdef FETCH_ABORT_EN
                fifo_abort_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tbit_q       <= tbit_d;
            seq_q        <= seq_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_thumb_q <= fifo_thumb_d;
`ifdef FETCH_ABORT_EN
            fifo_abort_q <= fifo_abort_d;
`endif
        end
    end

    assign bus.A          = pc_q;
    assign bus.nMREQ      = !req;
    assign bus.nOPC       = !req;
    assign bus.seq        = seq_q;
    assign bus.mas        = tbit_q ? 2'b01 : 2'b10;
    assign bus.tbit       = tbit_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head_valid ? fifo_data_q[rd_ptr_q]  : '0;
    assign bus.inst_pc    = head_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign bus.inst_thumb = head_valid ? fifo_thumb_q[rd_ptr_q] : 1'b0;
`ifdef FETCH_ABORT_EN
    assign bus.inst_abort = head_valid ? fifo_abort_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_arm_prefetch_unit.sv
// Testbench for arm_prefetch_unit: per-cycle vector table with a scoreboard
// of fetched instructions, plus reset-mid-access and (with FETCH_ABORT_EN)
// abort sequences.
module tb_arm_prefetch_unit;

    typedef struct {
        logic [31:0] a;
        logic        nmreq;
        logic        seq;
        logic [1:0]  mas;
        logic        ivld;
        logic        nw;
        logic [31:0] d;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        rth;
        logic        abort;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        thumb;
        logic        abort;
    } sb_t;

    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] H = 2'b01;

    logic mclk;
    logic nReset;
    int   n_vec;
    int   n_miss;
    sb_t  sb_q[$];
    vec_t tbl[28];
    vec_t post_rst[2];
    vec_t abt[7];

    arm_prefetch_unit_if #(.ADDR_W(32)) bus ();

    arm_prefetch_unit #(
        .ADDR_W      (32),
        .QUEUE_DEPTH (2),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .mclk  (mclk),
        .nReset(nReset),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    function automatic vec_t mk(input logic [31:0] a, input logic nmreq, input logic seq,
                                input logic [1:0] mas, input logic ivld, input logic nw,
                                input logic [31:0] d, input logic rdy, input logic rv,
                                input logic [31:0] rt, input logic rth);
        vec_t v;
        v.a = a; v.nmreq = nmreq; v.seq = seq; v.mas = mas; v.ivld = ivld;
        v.nw = nw; v.d = d; v.rdy = rdy; v.rv = rv; v.rt = rt; v.rth = rth;
        v.abort = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle: drive inputs, check outputs mid-cycle, update model.
    task automatic step(input string tag, input vec_t v);
        sb_t e;
        bus.nWAIT           = v.nw;
        bus.D               = v.d;
        bus.dec_ready       = v.rdy;
        bus.redirect_valid  = v.rv;
        bus.redirect_target = v.rt;
        bus.redirect_thumb  = v.rth;
`ifdef FETCH_ABORT_EN
        bus.abort           = v.abort;
`endif
        #1;
        chk({tag, " A"},     bus.A,          v.a);
        chk({tag, " nMREQ"}, 32'(bus.nMREQ), 32'(v.nmreq));
        chk({tag, " nOPC"},  32'(bus.nOPC),  32'(v.nmreq));
        chk({tag, " seq"},   32'(bus.seq),   32'(v.seq));
        chk({tag, " mas"},   32'(bus.mas),   32'(v.mas));
        chk({tag, " tbit"},  32'(bus.tbit),  32'(v.mas == H));
        chk({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(v.ivld));
        if (v.ivld && sb_q.size() != 0) begin
            chk({tag, " inst_data"},  bus.inst_data,         sb_q[0].data);
            chk({tag, " inst_pc"},    bus.inst_pc,           sb_q[0].pc);
            chk({tag, " inst_thumb"}, 32'(bus.inst_thumb),   32'(sb_q[0].thumb));
`ifdef FETCH_ABORT_EN
            chk({tag, " inst_abort"}, 32'(bus.inst_abort),   32'(sb_q[0].abort));
`endif
        end
        if (v.rv) begin
            sb_q.delete();
        end else begin
            if (v.ivld && v.rdy && sb_q.size() != 0) void'(sb_q.pop_front());
            if (!v.nmreq && v.nw) begin
                e.thumb = (v.mas == H);
                e.pc    = v.a;
                e.abort = v.abort;
                if (!e.thumb)   e.data = v.d;
                else if (v.a[1]) e.data = {16'h0000, v.d[31:16]};
                else             e.data = {16'h0000, v.d[15:0]};
                sb_q.push_back(e);
            end
        end
        @(negedge mclk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " nMREQ"},      32'(bus.nMREQ),      32'd1);
        chk({tag, " nOPC"},       32'(bus.nOPC),       32'd1);
        chk({tag, " seq"},        32'(bus.seq),        32'd0);
        chk({tag, " mas"},        32'(bus.mas),        32'(W));
        chk({tag, " A"},          bus.A,               32'h0);
        chk({tag, " inst_valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, " inst_data"},  bus.inst_data,       32'h0);
        chk({tag, " inst_pc"},    bus.inst_pc,         32'h0);
        chk({tag, " inst_thumb"}, 32'(bus.inst_thumb), 32'd0);
        chk({tag, " tbit"},       32'(bus.tbit),       32'd0);
`ifdef FETCH_ABORT_EN
        chk({tag, " inst_abort"}, 32'(bus.inst_abort), 32'd0);
`endif
    endtask

    initial begin
        //             A            nMREQ seq mas ivld nW D             rdy rv target        th
        tbl[0]  = mk(32'h0000_0000, 1, 0, W, 0, 1, 32'h0,          1, 0, 32'h0,          0);
        tbl[1]  = mk(32'h0000_0000, 0, 0, W, 0, 1, 32'hE3A0_0001,  1, 0, 32'h0,          0);
        tbl[2]  = mk(32'h0000_0004, 0, 1, W, 1, 1, 32'hE3A0_1002,  1, 0, 32'h0,          0);
        tbl[3]  = mk(32'h0000_0008, 0, 1, W, 1, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[4]  = mk(32'h0000_0008, 0, 1, W, 0, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[5]  = mk(32'h0000_0008, 0, 1, W, 0, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[6]  = mk(32'h0000_0008, 0, 1, W, 0, 1, 32'hE1A0_0000,  1, 0, 32'h0,          0);
        tbl[7]  = mk(32'h0000_000C, 0, 1, W, 1, 1, 32'hE3A0_2003,  0, 0, 32'h0,          0);
        tbl[8]  = mk(32'h0000_0010, 1, 1, W, 1, 1, 32'h0,          0, 0, 32'h0,          0);
        tbl[9]  = mk(32'h0000_0010, 1, 0, W, 1, 1, 32'h0,          0, 0, 32'h0,          0);
        tbl[10] = mk(32'h0000_0010, 1, 0, W, 1, 1, 32'h0,          1, 0, 32'h0,          0);
        tbl[11] = mk(32'h0000_0010, 0, 0, W, 1, 1, 32'hE3A0_3004,  0, 0, 32'h0,          0);
        tbl[12] = mk(32'h0000_0014, 1, 1, W, 1, 1, 32'h0,          1, 1, 32'h0000_0103,  1);
        tbl[13] = mk(32'h0000_0102, 0, 0, H, 0, 1, 32'hBEEF_1234,  1, 0, 32'h0,          0);
        tbl[14] = mk(32'h0000_0104, 0, 1, H, 1, 1, 32'h5678_4321,  1, 1, 32'h0000_0200,  0);
        tbl[15] = mk(32'h0000_0200, 0, 0, W, 0, 1, 32'hE1A0_1001,  1, 0, 32'h0,          0);
        tbl[16] = mk(32'h0000_0204, 0, 1, W, 1, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[17] = mk(32'h0000_0204, 0, 1, W, 0, 1, 32'hE1A0_2002,  1, 0, 32'h0,          0);
        tbl[18] = mk(32'h0000_0208, 0, 1, W, 1, 0, 32'h0,          1, 1, 32'h0000_3003,  0);
        tbl[19] = mk(32'h0000_3000, 0, 0, W, 0, 1, 32'hE1A0_3003,  0, 0, 32'h0,          0);
        tbl[20] = mk(32'h0000_3004, 0, 1, W, 1, 1, 32'hE1A0_4004,  0, 1, 32'hFFFF_FFFF,  1);
        tbl[21] = mk(32'hFFFF_FFFE, 0, 0, H, 0, 1, 32'hAAAA_5555,  1, 0, 32'h0,          0);
        tbl[22] = mk(32'h0000_0000, 0, 1, H, 1, 1, 32'h1111_2222,  1, 0, 32'h0,          0);
        tbl[23] = mk(32'h0000_0002, 0, 1, H, 1, 1, 32'h3333_4444,  1, 0, 32'h0,          0);
        tbl[24] = mk(32'h0000_0004, 0, 1, H, 1, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[25] = mk(32'h0000_0004, 0, 1, H, 0, 0, 32'h0,          1, 0, 32'h0,          0);
        tbl[26] = mk(32'h0000_0004, 0, 1, H, 0, 1, 32'h9999_8888,  0, 0, 32'h0,          0);
        tbl[27] = mk(32'h0000_0006, 0, 1, H, 1, 0, 32'h0,          0, 0, 32'h0,          0);

        post_rst[0] = mk(32'h0, 1, 0, W, 0, 1, 32'h0, 0, 0, 32'h0, 0);
        post_rst[1] = mk(32'h0, 0, 0, W, 0, 0, 32'h0, 0, 0, 32'h0, 0);

        abt[0] = mk(32'h0000_0000, 0, 0, W, 0, 0, 32'h0,         0, 1, 32'h0000_0010, 0);
        abt[1] = mk(32'h0000_0010, 0, 0, W, 0, 1, 32'hE7F0_00F0, 0, 0, 32'h0,         0);
        abt[1].abort = 1'b1;
        abt[2] = mk(32'h0000_0014, 1, 1, W, 1, 1, 32'h0,         0, 0, 32'h0,         0);
        abt[3] = mk(32'h0000_0014, 1, 0, W, 1, 1, 32'h0,         1, 0, 32'h0,         0);
        abt[4] = mk(32'h0000_0014, 1, 0, W, 0, 1, 32'h0,         0, 1, 32'h0000_0018, 0);
        abt[5] = mk(32'h0000_0018, 0, 0, W, 0, 1, 32'hE1A0_5005, 0, 0, 32'h0,         0);
        abt[6] = mk(32'h0000_001C, 0, 1, W, 1, 0, 32'h0,         0, 0, 32'h0,         0);

        n_vec  = 0;
        n_miss = 0;
        nReset              = 1'b0;
        bus.nWAIT           = 1'b1;
        bus.D               = '0;
        bus.dec_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.redirect_thumb  = 1'b0;
`ifdef FETCH_ABORT_EN
        bus.abort           = 1'b0;
`endif

        repeat (2) @(negedge mclk);
        #1;
        chk_reset_outputs("reset");
        @(negedge mclk);
        nReset = 1'b1;

        for (int i = 0; i < 28; i++) step($sformatf("row%0d", i), tbl[i]);

        // Reset asserted during a wait state with one entry buffered
        nReset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb_q.delete();
        @(negedge mclk);
        nReset = 1'b1;
        for (int i = 0; i < 2; i++) step($sformatf("postrst%0d", i), post_rst[i]);

`ifdef FETCH_ABORT_EN
        for (int i = 0; i < 7; i++) step($sformatf("abort%0d", i), abt[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
